// File: rtl/im_loader.sv
// Byte-stream loader for the instruction memory: assembles big-endian words and writes them.
// Optional IM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte check.
module im_loader #(
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [12:0] word_cnt,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [32:0] IM_END =
    {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DONE = 3'd2,
    S_ERR  = 3'd3
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    S_CHK  = 3'd4
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [12:0] rem_q, rem_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] word_q, word_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic [32:0] end_addr;
  logic        bad_req;
  logic        xfer;

  // End address is computed one bit wider so an overflowing request is rejected.
  always_comb begin
    end_addr = {1'b0, base_addr} + {18'b0, word_cnt, 2'b00};
    bad_req  = (base_addr[1:0] != 2'b00) ||
               (base_addr < IM_BASE) ||
               (end_addr > IM_END);
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        in_ready = (rem_q != 13'd0);
        cpu_hold = 1'b1;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
`endif
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
    xfer = in_valid & in_ready;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    bidx_d      = bidx_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (bad_req) begin
            state_d = S_ERR;
          end else if (word_cnt == 13'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            addr_d  = base_addr;
            rem_d   = word_cnt;
            bidx_d  = 2'd0;
            word_d  = 32'd0;
`ifdef IM_LOADER_CHECKSUM_EN
            sum_d   = 8'd0;
`endif
          end
        end
      end
      S_LOAD: begin
        if (rem_q == 13'd0) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else if (xfer) begin
          word_d = {word_q[23:0], in_data};
          bidx_d = bidx_q + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_data;
`endif
          if (bidx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = word_d;
            addr_d      = addr_q + 32'd4;
            rem_d       = rem_q - 13'd1;
          end
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_d = (in_data == sum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'd0;
      rem_q       <= 13'd0;
      bidx_q      <= 2'd0;
      word_q      <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      bidx_q      <= bidx_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected IM writes are queued as words are sent.
// Covers IM_LOADER_CHECKSUM_EN builds as well.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [12:0] word_cnt = 13'd0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  im_loader dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          due;
  } wr_t;

  wr_t        sb[$];
  int         cyc = 0;
  int         n_run = 0;
  int         n_fail = 0;
  logic [7:0] tb_sum = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check("we_hold", {31'd0, cpu_hold}, 32'd1);
      if (sb.size() == 0) begin
        check("spurious_we", mem_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", mem_addr, e.a);
        check("wr_data", mem_wdata, e.d);
        check("wr_lat", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [12:0] c);
    base_addr = b;
    word_cnt  = c;
    start     = 1'b1;
    tb_sum    = 8'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    logic rdy;
    bit   ok;
    ok       = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] a,
                           input logic [31:0] w,
                           input int maxgap);
    for (int i = 0; i < 4; i++) begin
      put_byte(w[31-8*i -: 8]);
      tb_sum = tb_sum + w[31-8*i -: 8];
      if (i < 3 && maxgap > 0) idle($urandom_range(maxgap, 0));
    end
    sb.push_back('{a, w, cyc});
  endtask

  task automatic finish_load();
`ifdef IM_LOADER_CHECKSUM_EN
    put_byte(tb_sum);
`else
    idle(1);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdy"},  {31'd0, in_ready}, 32'd0);
    check({tag, "_we"},   {31'd0, mem_we},   32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_done"}, {31'd0, done},     32'd0);
    check({tag, "_err"},  {31'd0, err},      32'd0);
    check({tag, "_addr"}, mem_addr,          32'd0);
    check({tag, "_data"}, mem_wdata,         32'd0);
  endtask

  initial begin
    int c0;
    #12;
    check_zero("rst");
    rst_n = 1'b1;
    idle(2);

    // 1: two words back-to-back
    do_start(32'h3000, 13'd2);
    check("t1_hold", {31'd0, cpu_hold}, 32'd1);
    c0 = cyc;
    send_word(32'h3000, 32'h1234_5678, 0);
    check("t1_rdy_mid", {31'd0, in_ready}, 32'd1);
    send_word(32'h3004, 32'h9ABC_DEF0, 0);
    check("t1_b2b", 32'(cyc - c0), 32'd8);
    check("t1_rdy_last", {31'd0, in_ready}, 32'd0);
    check("t1_hold_wr", {31'd0, cpu_hold}, 32'd1);
    finish_load();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_unhold", {31'd0, cpu_hold}, 32'd0);

    // 2: handler area with valid gaps
    do_start(32'h4180, 13'd1);
    check("t2_hold", {31'd0, cpu_hold}, 32'd1);
    check("t2_done_clr", {31'd0, done}, 32'd0);
    send_word(32'h4180, 32'hDEAD_BEEF, 3);
    check("t2_hold_wr", {31'd0, cpu_hold}, 32'd1);
    finish_load();
    check("t2_done", {31'd0, done}, 32'd1);

    // 3: rejected requests and the last legal word
    do_start(32'h3002, 13'd1);
    check("t3_err_align", {31'd0, err}, 32'd1);
    check("t3_rdy", {31'd0, in_ready}, 32'd0);
    check("t3_hold", {31'd0, cpu_hold}, 32'd0);
    idle(3);
    do_start(32'h6FFC, 13'd2);
    check("t3_err_ovf", {31'd0, err}, 32'd1);
    do_start(32'h2FFC, 13'd1);
    check("t3_err_low", {31'd0, err}, 32'd1);
    do_start(32'h6FFC, 13'd1);
    check("t3_err_clr", {31'd0, err}, 32'd0);
    check("t3_hold_ok", {31'd0, cpu_hold}, 32'd1);
    send_word(32'h6FFC, 32'hA5A5_0F0F, 1);
    finish_load();
    check("t3_done", {31'd0, done}, 32'd1);

    // 4: asynchronous reset mid-word
    do_start(32'h3000, 13'd1);
    put_byte(8'h11);
    put_byte(8'h22);
    rst_n = 1'b0;
    #1;
    check_zero("t4");
    idle(1);
    rst_n = 1'b1;
    idle(1);
    do_start(32'h3010, 13'd1);
    send_word(32'h3010, 32'hCAFE_BABE, 0);
    finish_load();
    check("t4_done", {31'd0, done}, 32'd1);

    // 5: empty load, then start ignored during a load
    do_start(32'h3000, 13'd0);
    check("t5_done0", {31'd0, done}, 32'd1);
    check("t5_hold0", {31'd0, cpu_hold}, 32'd0);
    do_start(32'h3100, 13'd2);
    send_word(32'h3100, 32'h0102_0304, 0);
    base_addr = 32'h3200;
    word_cnt  = 13'd1;
    start     = 1'b1;
    idle(1);
    start = 1'b0;
    check("t5_still_load", {31'd0, cpu_hold}, 32'd1);
    send_word(32'h3104, 32'h0506_0708, 2);
    finish_load();
    check("t5_done", {31'd0, done}, 32'd1);

`ifdef IM_LOADER_CHECKSUM_EN
    // 6: checksum byte good then bad
    do_start(32'h3000, 13'd1);
    send_word(32'h3000, 32'h0102_0304, 0);
    idle(1);
    check("t6_chk_hold", {31'd0, cpu_hold}, 32'd1);
    check("t6_chk_rdy", {31'd0, in_ready}, 32'd1);
    put_byte(8'h0A);
    check("t6_done", {31'd0, done}, 32'd1);
    do_start(32'h3000, 13'd1);
    send_word(32'h3000, 32'h0102_0304, 0);
    put_byte(8'h0B);
    check("t6_err", {31'd0, err}, 32'd1);
    check("t6_nodone", {31'd0, done}, 32'd0);
`endif

    idle(4);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
